seven_seg_scan_driver: RTL and testbench

//   Parametrised, time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.

---
 rtl/seven_seg_scan_driver_pkg.sv | 30 +++
 rtl/seven_seg_scan_timer.sv | 56 +++++
 rtl/seven_seg_scan_driver.sv | 118 +++++++++++
 tb/tb_seven_seg_scan_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants and hex decode for the multiplexed 7-segment driver.
// Segment patterns are active-low {A,B,C,D,E,F,G}.
package seven_seg_scan_driver_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0111000,
        7'b0110000,
        7'b1000010,
        7'b0110001,
        7'b1100000,
        7'b0001000,
        7'b0000100,
        7'b0000000,
        7'b0001111,
        7'b0100000,
        7'b0100100,
        7'b1001100,
        7'b0000110,
        7'b0010010,
        7'b1001111,
        7'b0000001
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot prescaler and digit index for the scan driver.
// Flags the anti-ghost window and pulses once per frame.
module seven_seg_scan_timer
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int IW         = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx_o,
    output logic          lit_win_o,
    output logic          wrap_o,
    output logic          frame_tick_o
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          tick_q;
    logic          slot_end;

    assign slot_end = (presc_q == PRESC_LAST);
    assign wrap_o   = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        presc_d = slot_end ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            tick_q  <= wrap_o;
        end
    end

    assign idx_o        = idx_q;
    assign lit_win_o    = (presc_q >= BLANK_END);
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with shadow/active
// registers so a new word only takes effect at a frame boundary.
module seven_seg_scan_driver
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [IW-1:0]           idx;
    logic                    lit_win;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] sh_val_q, act_val_q;
    logic [NUM_DIGITS-1:0]   sh_blank_q, act_blank_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q, act_dp_q;
    logic                    pending_q;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;
    logic [3:0]              nib;
    logic                    lit;

    seven_seg_scan_timer #(
        .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .IW        (IW)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_o       (idx),
        .lit_win_o   (lit_win),
        .wrap_o      (wrap),
        .frame_tick_o(frame_tick)
    );

    // A digit is a leading zero when it and everything above it is zero.
    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (act_val_q[4*i +: 4] == 4'h0);
            supp[i]  = lz_suppress && zero_run;
        end
    end

    always_comb begin
        nib   = 4'(act_val_q >> {idx, 2'b00});
        lit   = lit_win && !act_blank_q[idx] && !supp[idx];
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = ~(NUM_DIGITS'(1) << idx);
            seg_d = hex_to_seg(nib);
            dp_d  = ~act_dp_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val_q    <= '0;
            sh_blank_q  <= '0;
            sh_dp_q     <= '0;
            act_val_q   <= '0;
            act_blank_q <= '0;
            act_dp_q    <= '0;
            pending_q   <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            an_q        <= '1;
        end else begin
            if (wrap && pending_q) begin
                act_val_q   <= sh_val_q;
                act_blank_q <= sh_blank_q;
                act_dp_q    <= sh_dp_q;
                pending_q   <= 1'b0;
            end
            // A load on the wrap edge lands in the shadow and stays pending.
            if (load) begin
                sh_val_q   <= value;
                sh_blank_q <= blank_mask;
                sh_dp_q    <= dp_in;
                pending_q  <= 1'b1;
            end
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized self-checking bench for seven_seg_scan_driver against a
// frame-position reference model.
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_suppress = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] ref_lut [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [15:0] m_sh_val, m_act_val;
    logic [3:0]  m_sh_blank, m_act_blank, m_sh_dp, m_act_dp;
    logic        m_pend;
    int          n;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ft;

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .dp_in      (dp_in),
        .lz_suppress(lz_suppress),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, want);
        end
    endtask

    task automatic model_reset();
        m_sh_val = '0; m_act_val = '0;
        m_sh_blank = '0; m_act_blank = '0;
        m_sh_dp = '0; m_act_dp = '0;
        m_pend = 1'b0;
        n = 0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    endtask

    function automatic bit is_dark(int d);
        bit lead_zero;
        lead_zero = lz_suppress && d > 0 && ((m_act_val >> (4 * d)) == 16'h0);
        return m_act_blank[d] || lead_zero;
    endfunction

    // Model of one clock edge, from the position inside the frame.
    task automatic model_edge();
        int  p, d, ph;
        bit  lit;
        logic [3:0] nib;
        p   = n % FRAME;
        d   = p / SD;
        ph  = p % SD;
        lit = (ph >= BC) && !is_dark(d);
        nib = 4'(m_act_val >> (4 * d));
        e_an  = lit ? ~(4'b0001 << d) : 4'hF;
        e_seg = lit ? ref_lut[nib] : 7'h7F;
        e_dp  = lit ? ~m_act_dp[d] : 1'b1;
        e_ft  = (p == FRAME - 1);
        if (p == FRAME - 1 && m_pend) begin
            m_act_val = m_sh_val; m_act_blank = m_sh_blank; m_act_dp = m_sh_dp;
            m_pend = 1'b0;
        end
        if (load) begin
            m_sh_val = value; m_sh_blank = blank_mask; m_sh_dp = dp_in;
            m_pend = 1'b1;
        end
        n++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        load = 1'b0;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("frame_tick", 32'(frame_tick), 32'(e_ft));
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] m, input logic [3:0] d);
        value = v; blank_mask = m; dp_in = d; load = 1'b1;
        tick();
    endtask

    // Advance until the next edge is at frame position pos.
    task automatic align(input int pos);
        for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) tick();
        chk("align", 32'(n % FRAME), 32'(pos));
    endtask

    task automatic reset_checks();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;

        cycles(FRAME + 3);
        load_word(16'h1234, 4'h0, 4'h0);
        cycles(2 * FRAME);

        lz_suppress = 1'b1;
        load_word(16'h0070, 4'h0, 4'h0);
        cycles(2 * FRAME);
        lz_suppress = 1'b0;
        cycles(FRAME);

        align(0);
        load_word(16'hAAAA, 4'h0, 4'h0);
        cycles(2);
        load_word(16'hBCDE, 4'h0, 4'h0);
        cycles(2 * FRAME);

        load_word(16'hFFFF, 4'b0100, 4'b0001);
        cycles(2 * FRAME);

        align(5);
        load_word(16'h5A5A, 4'h0, 4'h0);
        align(FRAME - 1);
        load_word(16'hC3C3, 4'h0, 4'b1000);
        chk("wrap_load_pending", 32'(pending), 32'h1);
        cycles(2 * FRAME);

        // Asynchronous reset in the middle of a slot, with a load pending.
        load_word(16'h9876, 4'h0, 4'h0);
        cycles(6);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(FRAME + 2);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) lz_suppress = ~lz_suppress;
            if ($urandom_range(0, 9) == 0) begin
                value = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
                blank_mask = 4'($urandom) & 4'($urandom);
                dp_in = 4'($urandom);
                load = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
